// File: rtl/alu_md_pipe.sv
// Execute-stage ALU with a valid/ready handshake. Single-cycle ops register their result in
// one cycle; unsigned mul/mulhu/divu/remu iterate one bit per cycle.
module alu_md_pipe #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      alu_control,
   input  logic [WIDTH-1:0] alu_src1,
   input  logic [WIDTH-1:0] alu_src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   res_q, res_d;

   logic             accept;
   logic [WIDTH:0]   diff;
   logic             ltu, lts;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] op_res;
   logic             is_mul, is_div, is_hi;

   assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept     = in_valid & in_ready;
   assign out_valid  = (state_q == S_DONE);
   assign busy       = (state_q == S_MUL) | (state_q == S_DIV);
   assign alu_result = res_q;

   // One subtractor serves sub, slt and sltu; carry-out set means src1 >= src2 unsigned.
   assign diff  = {1'b0, alu_src1} + {1'b0, ~alu_src2} + (WIDTH+1)'(1);
   assign ltu   = ~diff[WIDTH];
   assign lts   = (alu_src1[WIDTH-1] ^ alu_src2[WIDTH-1]) ? alu_src1[WIDTH-1] : diff[WIDTH-1];
   assign shamt = alu_src1[SHW-1:0];

   always_comb begin
      op_res = '0;
      is_mul = 1'b0;
      is_div = 1'b0;
      is_hi  = 1'b0;
      if (alu_control[11])      op_res = alu_src1 + alu_src2;
      else if (alu_control[10]) op_res = diff[WIDTH-1:0];
      else if (alu_control[9])  op_res = {{(WIDTH-1){1'b0}}, lts};
      else if (alu_control[8])  op_res = {{(WIDTH-1){1'b0}}, ltu};
      else if (alu_control[7])  op_res = alu_src1 & alu_src2;
      else if (alu_control[6])  op_res = ~(alu_src1 | alu_src2);
      else if (alu_control[5])  op_res = alu_src1 | alu_src2;
      else if (alu_control[4])  op_res = alu_src1 ^ alu_src2;
      else if (alu_control[3])  op_res = alu_src2 << shamt;
      else if (alu_control[2])  op_res = alu_src2 >> shamt;
      else if (alu_control[1])  op_res = $signed(alu_src2) >>> shamt;
      else if (alu_control[0])  op_res = {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      else if (alu_control[15]) is_mul = 1'b1;
      else if (alu_control[14]) begin is_mul = 1'b1; is_hi = 1'b1; end
      else if (alu_control[13]) is_div = 1'b1;
      else if (alu_control[12]) begin is_div = 1'b1; is_hi = 1'b1; end
   end

   // Multiply: acc = {partial product, remaining multiplier bits}, add-then-shift-right.
   logic [WIDTH:0]     madd;
   logic [2*WIDTH-1:0] mul_nxt;
   assign madd    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_nxt = {madd, acc_q[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend shifting out / quotient shifting in}.
   logic [WIDTH:0]     dtmp, dsub;
   logic               qbit;
   logic [2*WIDTH-1:0] div_nxt;
   assign dtmp    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign dsub    = dtmp - {1'b0, opnd_q};
   assign qbit    = ~dsub[WIDTH];
   assign div_nxt = {(qbit ? dsub[WIDTH-1:0] : dtmp[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      res_d   = res_q;
      case (state_q)
         S_MUL: begin
            acc_d = mul_nxt;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               res_d   = hi_q ? mul_nxt[2*WIDTH-1:WIDTH] : mul_nxt[WIDTH-1:0];
            end
         end
         S_DIV: begin
            acc_d = div_nxt;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               res_d   = hi_q ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
            end
         end
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: ;
      endcase
      if (accept) begin
         if (is_mul) begin
            state_d = S_MUL;
            acc_d   = {{WIDTH{1'b0}}, alu_src2};
            opnd_d  = alu_src1;
            hi_d    = is_hi;
            cnt_d   = '0;
         end else if (is_div) begin
            state_d = S_DIV;
            acc_d   = {{WIDTH{1'b0}}, alu_src1};
            opnd_d  = alu_src2;
            hi_d    = is_hi;
            cnt_d   = '0;
         end else begin
            state_d = S_DONE;
            res_d   = op_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_alu_md_pipe.sv
// Bench for alu_md_pipe at WIDTH=32 and WIDTH=16: directed cases with literal answers, then
// randomized traffic with backpressure, all checked each cycle against a timing/value model.
module tb_alu_md_pipe;

   localparam logic [15:0] OP_ADD = 16'h0800, OP_SUB = 16'h0400, OP_SLT = 16'h0200;
   localparam logic [15:0] OP_SLTU = 16'h0100, OP_AND = 16'h0080, OP_NOR = 16'h0040;
   localparam logic [15:0] OP_XOR = 16'h0010, OP_SLL = 16'h0008;
   localparam logic [15:0] OP_SRL = 16'h0004, OP_SRA = 16'h0002, OP_LUI = 16'h0001;
   localparam logic [15:0] OP_MUL = 16'h8000, OP_MULHU = 16'h4000;
   localparam logic [15:0] OP_DIVU = 16'h2000, OP_REMU = 16'h1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s [2];
   logic        iv_s  [2];
   logic        or_s  [2];
   logic [15:0] ctl_s [2];
   logic [31:0] a_s   [2];
   logic [31:0] b_s   [2];
   logic        ov    [2];
   logic        rdy   [2];
   logic        bz    [2];
   logic [31:0] res   [2];
   logic [31:0] res32;
   logic [15:0] res16;

   assign res[0] = res32;
   assign res[1] = {16'h0, res16};

   alu_md_pipe #(.WIDTH(32), .SHW(5)) u_dut32 (
      .clk(clk), .reset(rst_s[0]), .in_valid(iv_s[0]), .in_ready(rdy[0]),
      .alu_control(ctl_s[0]), .alu_src1(a_s[0]), .alu_src2(b_s[0]),
      .out_valid(ov[0]), .out_ready(or_s[0]), .alu_result(res32), .busy(bz[0])
   );

   alu_md_pipe #(.WIDTH(16), .SHW(4)) u_dut16 (
      .clk(clk), .reset(rst_s[1]), .in_valid(iv_s[1]), .in_ready(rdy[1]),
      .alu_control(ctl_s[1]), .alu_src1(a_s[1][15:0]), .alu_src2(b_s[1][15:0]),
      .out_valid(ov[1]), .out_ready(or_s[1]), .alu_result(res16), .busy(bz[1])
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit rnd_bp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s w=%0d got=%h want=%h (cycle %0d)", nm, d ? 16 : 32, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm, input int d);
      checks++;
      errors++;
      $display("FAIL %s w=%0d timed out (cycle %0d)", nm, d ? 16 : 32, cyc);
   endtask

   function automatic int wd(input int d);
      return d ? 16 : 32;
   endfunction

   function automatic bit is_multi(input logic [15:0] c);
      return (c[11:0] == 12'h0) && (c[15:12] != 4'h0);
   endfunction

   // Reference result straight from the operation definitions, in 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [15:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
      longint unsigned m, ua, ub, r, p;
      longint sa, sb;
      int sh;
      m  = (64'd1 << w) - 64'd1;
      ua = {32'h0, a} & m;
      ub = {32'h0, b} & m;
      sa = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
      sb = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
      sh = int'(ua % longint'(w));
      p  = ua * ub;
      if (c[11])      r = ua + ub;
      else if (c[10]) r = ua - ub;
      else if (c[9])  r = (sa < sb) ? 64'd1 : 64'd0;
      else if (c[8])  r = (ua < ub) ? 64'd1 : 64'd0;
      else if (c[7])  r = ua & ub;
      else if (c[6])  r = ~(ua | ub);
      else if (c[5])  r = ua | ub;
      else if (c[4])  r = ua ^ ub;
      else if (c[3])  r = ub << sh;
      else if (c[2])  r = ub >> sh;
      else if (c[1])  r = longint'(sb >>> sh);
      else if (c[0])  r = (ub & ((64'd1 << (w / 2)) - 64'd1)) << (w / 2);
      else if (c[15]) r = p;
      else if (c[14]) r = p >> w;
      else if (c[13]) r = (ub == 0) ? m : ua / ub;
      else if (c[12]) r = (ub == 0) ? ua : ua % ub;
      else            r = 64'd0;
      r = r & m;
      return r[31:0];
   endfunction

   // Model state per DUT: at most one operation is outstanding at any time.
   bit          have [2] = '{1'b0, 1'b0};
   bit          rz   [2] = '{1'b1, 1'b1};
   logic [31:0] expv [2];
   int          due  [2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit vis, rdy_e;
         vis   = have[d] && (cyc >= due[d]);
         rdy_e = !have[d] || (vis && or_s[d]);
         if (cyc >= 2) begin
            chk("out_valid", d, {31'h0, ov[d]}, {31'h0, vis});
            chk("in_ready", d, {31'h0, rdy[d]}, {31'h0, rdy_e});
            chk("busy", d, {31'h0, bz[d]}, {31'h0, have[d] && !vis});
            if (vis)        chk("result", d, res[d], expv[d]);
            else if (rz[d]) chk("reset_result", d, res[d], 32'h0);
         end
         if (rst_s[d]) begin
            have[d] = 1'b0;
            rz[d]   = 1'b1;
         end else begin
            if (vis && or_s[d]) have[d] = 1'b0;
            if (iv_s[d] && rdy_e) begin
               have[d] = 1'b1;
               rz[d]   = 1'b0;
               expv[d] = model(ctl_s[d], a_s[d], b_s[d], wd(d));
               due[d]  = cyc + (is_multi(ctl_s[d]) ? wd(d) + 1 : 1);
            end
         end
      end
   end

   // Present an op until accepted; n = number of cycles it was presented.
   task automatic issue(input int d, input logic [15:0] c, input logic [31:0] a,
                        input logic [31:0] b, output int n);
      logic acc;
      iv_s[d] = 1'b1; ctl_s[d] = c; a_s[d] = a; b_s[d] = b;
      n = 0;
      do begin
         @(negedge clk);
         acc = rdy[d];
         @(posedge clk); #1;
         n++;
         if (rnd_bp && !acc) or_s[d] = 1'($urandom_range(0, 1));
      end while (!acc && n < 200);
      iv_s[d] = 1'b0;
      if (!acc) fail_now("issue", d);
      if (rnd_bp) or_s[d] = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_res(input int d, output int lat, output int bc);
      lat = 0; bc = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bz[d]) bc++;
      end while (!ov[d] && lat < 200);
      if (!ov[d]) fail_now("wait_result", d);
   endtask

   task automatic run_dir(input int d, input logic [15:0] c,
                          input logic [31:0] a32, input logic [31:0] b32, input logic [31:0] e32,
                          input logic [31:0] a16, input logic [31:0] b16, input logic [31:0] e16);
      int n, lat, bc;
      bit m;
      m = is_multi(c);
      issue(d, c, d ? a16 : a32, d ? b16 : b32, n);
      wait_res(d, lat, bc);
      chk("dir_result", d, res[d], d ? e16 : e32);
      chk("dir_latency", d, lat, m ? (d ? 17 : 33) : 1);
      chk("dir_busy_cycles", d, bc, m ? (d ? 16 : 32) : 0);
      @(posedge clk); #1;
   endtask

   task automatic suite(input int d);
      int n, lat, bc;
      or_s[d] = 1'b1;
      run_dir(d, OP_ADD, 32'h7FFFFFFF, 1, 32'h80000000, 32'h7FFF, 1, 32'h8000);
      run_dir(d, OP_SUB, 5, 7, 32'hFFFFFFFE, 5, 7, 32'hFFFE);
      run_dir(d, OP_SLT, 32'hFFFFFFFF, 1, 1, 32'hFFFF, 1, 1);
      run_dir(d, OP_SLTU, 32'hFFFFFFFF, 1, 0, 32'hFFFF, 1, 0);
      run_dir(d, OP_SRA, 4, 32'h80000000, 32'hF8000000, 4, 32'h8000, 32'hF800);
      run_dir(d, OP_SRL, 4, 32'h80000000, 32'h08000000, 4, 32'h8000, 32'h0800);
      run_dir(d, OP_SLL, 8, 1, 32'h100, 8, 1, 32'h100);
      run_dir(d, OP_LUI, 0, 32'h1234, 32'h12340000, 0, 32'h0012, 32'h1200);
      run_dir(d, OP_NOR, 0, 0, 32'hFFFFFFFF, 0, 0, 32'hFFFF);
      run_dir(d, OP_XOR, 32'h0F0F, 32'h00FF, 32'h0FF0, 32'h0F0F, 32'h00FF, 32'h0FF0);
      run_dir(d, 16'h0000, 32'h12, 32'h34, 0, 32'h12, 32'h34, 0);
      run_dir(d, OP_AND | OP_MUL, 32'hF0F0, 32'hFF00, 32'hF000, 32'hF0F0, 32'hFF00, 32'hF000);
      run_dir(d, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFF, 32'hFFFF, 32'hFFFE);
      run_dir(d, OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFF, 32'hFFFF, 1);
      run_dir(d, OP_DIVU, 100, 7, 14, 100, 7, 14);
      run_dir(d, OP_REMU, 100, 7, 2, 100, 7, 2);
      run_dir(d, OP_DIVU, 32'hDEADBEEF, 0, 32'hFFFFFFFF, 32'hBEEF, 0, 32'hFFFF);
      run_dir(d, OP_REMU, 32'h1234, 0, 32'h1234, 32'h1234, 0, 32'h1234);

      // Back-to-back single-cycle ops: the second is taken while the first is delivered.
      issue(d, OP_ADD, d ? 32'h7FFF : 32'h7FFFFFFF, 1, n);
      issue(d, OP_SUB, 5, 7, n);
      chk("b2b_present_cycles", d, n, 1);
      wait_res(d, lat, bc);
      chk("b2b_latency", d, lat, 1);
      chk("b2b_result", d, res[d], d ? 32'hFFFE : 32'hFFFFFFFE);
      @(posedge clk); #1;

      // Downstream stall holds the result; release lets the next op in that same cycle.
      or_s[d] = 1'b0;
      issue(d, OP_ADD, 3, 4, n);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", d, {31'h0, ov[d]}, 1);
         chk("bp_result", d, res[d], 7);
         chk("bp_in_ready", d, {31'h0, rdy[d]}, 0);
      end
      @(posedge clk); #1;
      or_s[d] = 1'b1;
      issue(d, OP_XOR, 32'hFF, 32'h0F, n);
      chk("bp_release_present_cycles", d, n, 1);
      wait_res(d, lat, bc);
      chk("bp_next_result", d, res[d], 32'hF0);
      @(posedge clk); #1;

      // Reset mid-multiply drops the operation.
      issue(d, OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
      repeat (10) @(posedge clk);
      #1 rst_s[d] = 1'b1;
      @(posedge clk); #1 rst_s[d] = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", d, {31'h0, ov[d]}, 0);
      chk("rst_result", d, res[d], 0);
      chk("rst_in_ready", d, {31'h0, rdy[d]}, 1);
      chk("rst_busy", d, {31'h0, bz[d]}, 0);
      repeat (wd(d) + 5) @(posedge clk);
      #1;

      // Random traffic with random out_ready.
      rnd_bp = 1'b1;
      for (int i = 0; i < 120; i++) begin
         logic [15:0] c;
         logic [31:0] a, b;
         int sel;
         sel = int'($urandom_range(0, 19));
         if (sel < 16)       c = 16'h1 << sel;
         else if (sel == 16) c = 16'h0;
         else                c = 16'($urandom);
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'hFFFFFFFF;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            or_s[d] = 1'($urandom_range(0, 1));
         end
         issue(d, c, a, b, n);
      end
      rnd_bp = 1'b0;
      or_s[d] = 1'b1;
      repeat (wd(d) + 10) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; iv_s[d] = 1'b0; or_s[d] = 1'b1;
         ctl_s[d] = '0; a_s[d] = '0; b_s[d] = '0;
      end
      // Pin the model to hand-computed values.
      chk("model_mulhu32", 0, model(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32), 32'hFFFFFFFE);
      chk("model_sra32", 0, model(OP_SRA, 4, 32'h80000000, 32), 32'hF8000000);
      chk("model_slt16", 1, model(OP_SLT, 32'hFFFF, 1, 16), 1);
      chk("model_remu0_16", 1, model(OP_REMU, 32'h1234, 0, 16), 32'h1234);
      chk("model_lui16", 1, model(OP_LUI, 0, 32'h0012, 16), 32'h1200);
      repeat (3) @(posedge clk);
      #1 rst_s[0] = 1'b0; rst_s[1] = 1'b0;
      @(posedge clk); #1;
      suite(0);
      suite(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
